// File: rtl/router_fifo_param_if.sv
// Router output-channel FIFO bus.
// master : router side, drives write/read requests, the header-load strobe
//          and write data.
// slave  : FIFO side, returns read data and its qualifiers, the
//          full/empty/almost flags, the occupancy count and the sticky
//          error flags.
interface router_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 4
);
    logic                  write_enb;
    logic                  read_enb;
    logic                  lfd_state;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  pkt_end;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [AW:0]           occupancy;
    logic                  overflow_err;
    logic                  underflow_err;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, data_valid, pkt_end, full, empty,
               almost_full, almost_empty, occupancy,
               overflow_err, underflow_err
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, data_valid, pkt_end, full, empty,
               almost_full, almost_empty, occupancy,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/router_fifo_param.sv
// Parametrised packet FIFO for one router output channel.
// Every stored byte carries a start-of-packet tag. The tag is taken from
// lfd_state delayed by one clock, so it lines up with the header write.
// On the read side a packet counter follows the header length field and
// pulses pkt_end together with the parity byte.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   soft_reset : synchronous channel flush, lower priority than reset
//   bus        : router_fifo_param_if.slave, carrying the write/read
//                requests and data, the flags, the occupancy count and
//                the sticky error flags
module router_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH),
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                soft_reset,
    router_fifo_param_if.slave  bus
);
    localparam int          CW      = DATA_WIDTH - 1;
    localparam logic [AW:0] AF_L    = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_L    = AE_LEVEL[AW:0];
    localparam logic [AW:0] PT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW:0]         wr_pt, rd_pt;
    logic                lfd_d;
    logic [CW-1:0]       pkt_cnt;
    logic                flush, wr_en, rd_en;
    logic [DATA_WIDTH:0] rd_entry;

    // full/empty use the pre-edge pointers. On a simultaneous request a full
    // FIFO therefore drops the write, and an empty FIFO ignores the read.
    assign bus.empty        = (wr_pt == rd_pt);
    assign bus.full         = (wr_pt == {~rd_pt[AW], rd_pt[AW-1:0]});
    assign bus.occupancy    = wr_pt - rd_pt;
    assign bus.almost_full  = (bus.occupancy >= AF_L);
    assign bus.almost_empty = (bus.occupancy <= AE_L);

    assign flush    = reset | soft_reset;
    assign wr_en    = bus.write_enb & ~bus.full & ~flush;
    assign rd_en    = bus.read_enb & ~bus.empty;
    assign rd_entry = mem[rd_pt[AW-1:0]];

    // Storage is never cleared. After a flush the pointers make old
    // entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_pt[AW-1:0]] <= {lfd_d, bus.data_in};
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_pt             <= '0;
            rd_pt             <= '0;
            lfd_d             <= 1'b0;
            pkt_cnt           <= '0;
            bus.data_out      <= '0;
            bus.data_valid    <= 1'b0;
            bus.pkt_end       <= 1'b0;
            bus.overflow_err  <= 1'b0;
            bus.underflow_err <= 1'b0;
        end else begin
            lfd_d <= bus.lfd_state;

            if (wr_en)
                wr_pt <= wr_pt + PT_ONE;
            if (bus.write_enb && bus.full)
                bus.overflow_err <= 1'b1;
            if (bus.read_enb && bus.empty)
                bus.underflow_err <= 1'b1;

            bus.data_valid <= rd_en;
            bus.pkt_end    <= 1'b0;
            if (rd_en) begin
                rd_pt        <= rd_pt + PT_ONE;
                bus.data_out <= rd_entry[DATA_WIDTH-1:0];
                if (rd_entry[DATA_WIDTH]) begin
                    // Header: the length field plus one, so the parity byte
                    // is counted. A zero-length packet ends on its next read.
                    pkt_cnt <= {1'b0, rd_entry[DATA_WIDTH-1:2]} + CNT_ONE;
                end else if (pkt_cnt != '0) begin
                    pkt_cnt     <= pkt_cnt - CNT_ONE;
                    bus.pkt_end <= (pkt_cnt == CNT_ONE);
                end
            end
        end
    end
endmodule

// File: tb/tb_router_fifo_param.sv
module tb_router_fifo_param;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic reset;
    logic soft_reset;

    router_fifo_param_if #(.DATA_WIDTH(DW), .AW(AW)) bif ();

    router_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: a queue of {sop, byte} plus the number of
    // bytes still owed by the packet currently being read.
    bit [DW:0]   q[$];
    int          remaining;
    bit          prev_lfd;
    logic [DW-1:0] m_dout;
    bit          m_dv, m_pe, m_ovf, m_udf;

    task automatic cycle(input bit we, input bit re, input bit lfd,
                         input logic [DW-1:0] din, input bit sr, input bit rst);
        bit [DW:0] e;
        bit full_m, empty_m;
        @(negedge clk);
        bif.write_enb = we;
        bif.read_enb  = re;
        bif.lfd_state = lfd;
        bif.data_in   = din;
        soft_reset    = sr;
        reset         = rst;
        @(posedge clk);
        full_m  = (q.size() == DEPTH);
        empty_m = (q.size() == 0);
        if (rst || sr) begin
            q.delete();
            remaining = 0;
            prev_lfd  = 0;
            m_dout = '0; m_dv = 0; m_pe = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (we && full_m) m_ovf = 1;
            if (re && empty_m) m_udf = 1;
            m_pe = 0;
            m_dv = 0;
            if (re && !empty_m) begin
                e = q.pop_front();
                m_dout = e[DW-1:0];
                m_dv = 1;
                if (e[DW]) begin
                    remaining = int'(e[DW-1:2]) + 1;
                end else if (remaining > 0) begin
                    remaining = remaining - 1;
                    m_pe = (remaining == 0);
                end
            end
            if (we && !full_m) q.push_back({prev_lfd, din});
            prev_lfd = lfd;
        end
        #1;
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, '0, 0, 1);
        cycle(0, 0, 0, '0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bif.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %0h expected 0", bif.data_out); end
        checks++; if (bif.data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %0b expected 0", bif.data_valid); end
        checks++; if (bif.pkt_end !== 1'b0) begin errors++; $display("FAIL reset_pkt_end: got %0b expected 0", bif.pkt_end); end
        checks++; if (bif.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", bif.full); end
        checks++; if (bif.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", bif.empty); end
        checks++; if (bif.almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %0b expected 0", bif.almost_full); end
        checks++; if (bif.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %0b expected 1", bif.almost_empty); end
        checks++; if (bif.occupancy !== 5'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", bif.occupancy); end
        checks++; if (bif.overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", bif.overflow_err); end
        checks++; if (bif.underflow_err !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %0b expected 0", bif.underflow_err); end
    endtask

    task automatic test_packet();
        logic [DW-1:0] bytes [5];
        do_reset();
        bytes[0] = 8'h0D;
        for (int i = 1; i < 5; i++) bytes[i] = DW'($urandom);
        cycle(0, 0, 1, '0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, bytes[i], 0, 0);
        checks++; if (bif.occupancy !== 5'd5) begin errors++; $display("FAIL pkt_occupancy: got %0d expected 5", bif.occupancy); end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, '0, 0, 0);
            checks++; if (bif.data_valid !== 1'b1) begin errors++; $display("FAIL pkt_valid[%0d]: got %0b expected 1", i, bif.data_valid); end
            checks++; if (bif.data_out !== bytes[i]) begin errors++; $display("FAIL pkt_data[%0d]: got %0h expected %0h", i, bif.data_out, bytes[i]); end
            checks++; if (bif.pkt_end !== (i == 4)) begin errors++; $display("FAIL pkt_end[%0d]: got %0b expected %0b", i, bif.pkt_end, (i == 4)); end
        end
        checks++; if (bif.empty !== 1'b1) begin errors++; $display("FAIL pkt_empty_after: got %0b expected 1", bif.empty); end
        cycle(0, 0, 0, '0, 0, 0);
        checks++; if (bif.data_valid !== 1'b0) begin errors++; $display("FAIL pkt_valid_idle: got %0b expected 0", bif.data_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 0, DW'($urandom), 0, 0);
            checks++; if (bif.almost_full !== (q.size() >= DEPTH - 2)) begin errors++; $display("FAIL af_at_%0d: got %0b expected %0b", q.size(), bif.almost_full, (q.size() >= DEPTH - 2)); end
            checks++; if (bif.almost_empty !== (q.size() <= 2)) begin errors++; $display("FAIL ae_at_%0d: got %0b expected %0b", q.size(), bif.almost_empty, (q.size() <= 2)); end
        end
        checks++; if (bif.full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b expected 1", bif.full); end
        checks++; if (bif.occupancy !== 5'd16) begin errors++; $display("FAIL full_occupancy: got %0d expected 16", bif.occupancy); end
        checks++; if (bif.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b expected 0", bif.overflow_err); end
        cycle(1, 0, 0, 8'hEE, 0, 0);
        checks++; if (bif.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", bif.overflow_err); end
        checks++; if (bif.occupancy !== 5'd16) begin errors++; $display("FAIL ovf_occupancy: got %0d expected 16", bif.occupancy); end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(0, 1, 0, '0, 0, 0);
        checks++; if (bif.underflow_err !== 1'b1) begin errors++; $display("FAIL udf_set: got %0b expected 1", bif.underflow_err); end
        checks++; if (bif.data_valid !== 1'b0) begin errors++; $display("FAIL udf_valid: got %0b expected 0", bif.data_valid); end
        checks++; if (bif.data_out !== 8'h00) begin errors++; $display("FAIL udf_data: got %0h expected 0", bif.data_out); end
        // Simultaneous write on an empty FIFO: the write lands and the read is ignored.
        cycle(1, 1, 0, 8'h5A, 0, 0);
        checks++; if (bif.data_valid !== 1'b0) begin errors++; $display("FAIL empty_rw_valid: got %0b expected 0", bif.data_valid); end
        checks++; if (bif.occupancy !== 5'd1) begin errors++; $display("FAIL empty_rw_occ: got %0d expected 1", bif.occupancy); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] first;
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, DW'($urandom), 0, 0);
        first = q[0][DW-1:0];
        cycle(1, 1, 0, 8'hC3, 0, 0);
        checks++; if (bif.occupancy !== 5'd15) begin errors++; $display("FAIL full_rw_occ: got %0d expected 15", bif.occupancy); end
        checks++; if (bif.data_out !== first) begin errors++; $display("FAIL full_rw_data: got %0h expected %0h", bif.data_out, first); end
        checks++; if (bif.full !== 1'b0) begin errors++; $display("FAIL full_rw_full: got %0b expected 0", bif.full); end
        // Stream: pointers wrap several times; every cycle is compared with the model.
        for (int i = 0; i < 300; i++) begin
            bit we, re, lfd;
            we  = (i < 40) ? ((i % 2) == 0) || ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) != 0);
            re  = (i < 40) ? ((i % 2) == 1) || ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) != 0);
            lfd = ($urandom_range(0, 7) == 0);
            cycle(we, re, lfd, DW'($urandom), 0, 0);
            checks++; if (bif.data_valid !== m_dv) begin errors++; $display("FAIL stream_valid[%0d]: got %0b expected %0b", i, bif.data_valid, m_dv); end
            checks++; if (bif.data_out !== m_dout) begin errors++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, bif.data_out, m_dout); end
            checks++; if (bif.pkt_end !== m_pe) begin errors++; $display("FAIL stream_pkt_end[%0d]: got %0b expected %0b", i, bif.pkt_end, m_pe); end
            checks++; if (bif.occupancy !== 5'(q.size())) begin errors++; $display("FAIL stream_occ[%0d]: got %0d expected %0d", i, bif.occupancy, q.size()); end
            checks++; if (bif.full !== (q.size() == DEPTH) || bif.empty !== (q.size() == 0)) begin errors++; $display("FAIL stream_flags[%0d]: got full=%0b empty=%0b expected size %0d", i, bif.full, bif.empty, q.size()); end
            checks++; if (bif.overflow_err !== m_ovf || bif.underflow_err !== m_udf) begin errors++; $display("FAIL stream_err[%0d]: got %0b%0b expected %0b%0b", i, bif.overflow_err, bif.underflow_err, m_ovf, m_udf); end
        end
    endtask

    task automatic test_soft_reset();
        do_reset();
        cycle(0, 1, 0, '0, 0, 0);
        cycle(0, 0, 1, '0, 0, 0);
        cycle(1, 0, 0, 8'h0D, 0, 0);
        cycle(1, 0, 0, 8'h11, 0, 0);
        cycle(1, 0, 0, 8'h22, 0, 0);
        cycle(0, 1, 0, '0, 0, 0);
        cycle(0, 1, 0, '0, 0, 0);
        checks++; if (bif.underflow_err !== 1'b1) begin errors++; $display("FAIL sr_udf_before: got %0b expected 1", bif.underflow_err); end
        cycle(0, 0, 0, '0, 1, 0);
        checks++; if (bif.empty !== 1'b1) begin errors++; $display("FAIL sr_empty: got %0b expected 1", bif.empty); end
        checks++; if (bif.occupancy !== 5'd0) begin errors++; $display("FAIL sr_occ: got %0d expected 0", bif.occupancy); end
        checks++; if (bif.underflow_err !== 1'b0 || bif.overflow_err !== 1'b0) begin errors++; $display("FAIL sr_errs: got %0b%0b expected 00", bif.overflow_err, bif.underflow_err); end
        checks++; if (bif.pkt_end !== 1'b0 || bif.data_valid !== 1'b0) begin errors++; $display("FAIL sr_pe_dv: got %0b%0b expected 00", bif.pkt_end, bif.data_valid); end
        checks++; if (bif.data_out !== 8'h00) begin errors++; $display("FAIL sr_data_out: got %0h expected 0", bif.data_out); end
        cycle(0, 0, 1, '0, 0, 0);
        cycle(1, 0, 0, 8'h02, 0, 0);
        cycle(1, 0, 0, 8'h77, 0, 0);
        cycle(0, 1, 0, '0, 0, 0);
        checks++; if (bif.pkt_end !== 1'b0 || bif.data_out !== 8'h02) begin errors++; $display("FAIL len0_hdr: got pe=%0b data=%0h expected pe=0 data=02", bif.pkt_end, bif.data_out); end
        cycle(0, 1, 0, '0, 0, 0);
        checks++; if (bif.pkt_end !== 1'b1 || bif.data_out !== 8'h77) begin errors++; $display("FAIL len0_parity: got pe=%0b data=%0h expected pe=1 data=77", bif.pkt_end, bif.data_out); end
        cycle(0, 0, 0, '0, 0, 0);
        checks++; if (bif.pkt_end !== 1'b0) begin errors++; $display("FAIL len0_pulse_width: got %0b expected 0", bif.pkt_end); end
    endtask

    task automatic test_reset_combo();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, DW'($urandom), 0, 0);
        cycle(0, 1, 0, '0, 0, 0);
        cycle(1, 1, 1, 8'hAA, 1, 1);
        checks++; if (bif.occupancy !== 5'd0 || bif.empty !== 1'b1) begin errors++; $display("FAIL combo_occ: got %0d empty=%0b expected 0 empty=1", bif.occupancy, bif.empty); end
        checks++; if (bif.data_valid !== 1'b0 || bif.data_out !== 8'h00) begin errors++; $display("FAIL combo_out: got dv=%0b data=%0h expected 0 0", bif.data_valid, bif.data_out); end
        checks++; if (bif.almost_empty !== 1'b1 || bif.full !== 1'b0) begin errors++; $display("FAIL combo_flags: got ae=%0b full=%0b expected 1 0", bif.almost_empty, bif.full); end
        // The delayed lfd must also have been cleared: the next byte is untagged.
        cycle(1, 0, 0, 8'h3C, 0, 0);
        cycle(0, 1, 0, '0, 0, 0);
        checks++; if (bif.data_out !== 8'h3C || bif.data_valid !== 1'b1) begin errors++; $display("FAIL combo_next: got data=%0h dv=%0b expected 3c 1", bif.data_out, bif.data_valid); end
        checks++; if (bif.pkt_end !== m_pe) begin errors++; $display("FAIL combo_pe: got %0b expected %0b", bif.pkt_end, m_pe); end
    endtask

    initial begin
        reset = 1'b1;
        soft_reset = 1'b0;
        bif.write_enb = 1'b0;
        bif.read_enb = 1'b0;
        bif.lfd_state = 1'b0;
        bif.data_in = '0;
        remaining = 0;
        prev_lfd = 0;
        m_dout = '0; m_dv = 0; m_pe = 0; m_ovf = 0; m_udf = 0;
        test_reset();
        test_packet();
        test_full();
        test_underflow();
        test_back_to_back();
        test_soft_reset();
        test_reset_combo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_fifo_param.md
# router_fifo_param

Parametrised packet FIFO for the router output channels; the next generation of the fixed 16×8 output FIFO. One instance sits between the router register block and each destination port. It stores bytes tagged with a start-of-packet bit and tracks packet boundaries on the read side. Compared with the fixed FIFO it adds width/depth parameters, occupancy and almost-full/almost-empty flags, a registered data-valid qualifier instead of tri-stating data_out, an end-of-packet pulse, and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 8: byte width. Must be ≥ 3.
- DEPTH, 16: number of entries. Power of 2, ≥ 4.
- AW, log2(DEPTH): address width.
- AF_LEVEL, DEPTH-2: almost_full asserts when occupancy ≥ AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when occupancy ≤ AE_LEVEL.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  synchronous channel flush (timeout from the sync block).
- write_enb  in  1  write request.
- read_enb  in  1  read request.
- lfd_state  in  1  header-load indication from the router FSM.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  data_out carries a byte read on the previous edge.
- pkt_end  out  1  one-cycle pulse with the last byte (parity) of a packet.
- full, empty  out  1  combinational from the pointers.
- almost_full, almost_empty  out  1  combinational from occupancy.
- occupancy  out  AW+1  number of stored entries, 0..DEPTH.
- overflow_err, underflow_err  out  1  sticky error flags.

## Operation
- Storage: DEPTH × (DATA_WIDTH+1). Bit DATA_WIDTH is the SOP tag.
- The tag written is lfd_state registered by one clk, so it aligns with the header write.
- Pointers: wr_pt and rd_pt are AW+1 bits, with the MSB as the wrap bit.
  - empty = (wr_pt == rd_pt).
  - full = (wr_pt == {~rd_pt[AW], rd_pt[AW-1:0]}).
  - occupancy = wr_pt − rd_pt, modulo 2^(AW+1).
- Write: when write_enb && !full, store {tag, data_in} at wr_pt[AW-1:0] and increment wr_pt.
  - write_enb && full: the write is dropped and overflow_err is set.
- Read: when read_enb && !empty, data_out ← mem[rd_pt][DATA_WIDTH-1:0], data_valid ← 1, and rd_pt increments.
  - Otherwise data_valid ← 0 and data_out holds its value.
  - read_enb && empty: underflow_err is set.
- Packet counter (width DATA_WIDTH−1):
  - On reading a tagged entry, load with header[DATA_WIDTH-1:2] + 1 (payload plus parity).
  - On reading an untagged entry with a nonzero counter, decrement.
  - When a read decrements the counter from 1 to 0, pkt_end ← 1 for one cycle, coincident with data_valid.
  - A header with length 0 loads 1; the next read (parity) ends the packet.
- Simultaneous read and write:
  - Both proceed when neither full nor empty.
  - When full, the read proceeds and the write is dropped, because full is evaluated before the edge.
  - When empty, the write proceeds and the read is ignored.
- Error flags clear only on reset or soft_reset.
- Priority: reset > soft_reset > normal operation.
- Effect of reset or soft_reset:
  - Pointers, packet counter, lfd delay register, both error flags, data_valid, pkt_end and data_out all clear to 0.
  - Memory contents are not cleared; the pointers make them unreachable.

## Timing
- Reset values: data_out=0, data_valid=0, pkt_end=0, full=0, empty=1, almost_full=0, almost_empty=1, occupancy=0, overflow_err=0, underflow_err=0.
- Read latency is 1 clk: data_out and data_valid update on the edge that samples read_enb.
- Flag latency:
  - empty falls and occupancy increments the cycle after the edge that accepted a write.
  - full falls the cycle after the edge that accepted a read.
- Throughput: one write and one read per clk sustained.
- Wrap-around: pointers wrap at 2^(AW+1) with no stall.
- soft_reset mid-packet: a partially read packet is abandoned, pkt_end is not generated, and the next tagged read starts cleanly.

## Test plan
- Reset, then write header 8'h0D (len=3, addr=1) + 3 payload + parity, then read 5 → data_valid high 5 cycles; pkt_end high only with the parity byte; empty=1 after.
- DEPTH=16: write 16 bytes → full=1, occupancy=16, almost_full=1 from occupancy 14; a 17th write → overflow_err=1 and occupancy stays 16.
- Read on empty after reset → underflow_err=1, data_valid=0, data_out=0.
- Full FIFO, read_enb and write_enb asserted together → occupancy 15, new byte not stored; 40 stream cycles with write and read interleaved → pointers wrap and the output order matches the input order.
- soft_reset after header + 1 payload read → next cycle empty=1, occupancy=0, errors=0, no pkt_end; a following packet with len=0 (header 8'h02, parity) → pkt_end with the 2nd read.
- reset and soft_reset asserted together mid-write → reset values, with no write committed.
